// File: rtl/sb_pkg.sv
// Shared definitions for the store buffer.
//   SB_DEPTH / SB_ADDR_W / SB_DATA_W : default buffer depth and datapath widths
//   sb_entry_t                       : one buffered store {address, data}
//   port_mode_t                      : who owns the DataMemory port this cycle
package sb_pkg;

    localparam int SB_DEPTH  = 4;
    localparam int SB_ADDR_W = 64;
    localparam int SB_DATA_W = 64;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] adr;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;

    // LOAD beats DRAIN; IDLE when neither is requested.
    typedef enum logic [1:0] {
        PORT_IDLE  = 2'd0,
        PORT_LOAD  = 2'd1,
        PORT_DRAIN = 2'd2
    } port_mode_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-match search over the buffered stores for load forwarding.
//   entry_adr/entry_data : storage array, indexed by physical slot
//   head, count          : oldest slot and number of occupied slots
//   ld_adr               : load address to look up
//   hit, data            : a valid entry matched; data of the youngest match
module sb_fwd_match
    import sb_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
) (
    input  logic [ADDR_W-1:0]         entry_adr  [DEPTH],
    input  logic [DATA_W-1:0]         entry_data [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]  head,
    input  logic [$clog2(DEPTH):0]    count,
    input  logic [ADDR_W-1:0]         ld_adr,
    output logic                      hit,
    output logic [DATA_W-1:0]         data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Re-order the slots by age: position 0 is the oldest (head), position
    // count-1 the youngest. Positions at or beyond count are not occupied.
    logic [DEPTH-1:0]  match_age;
    logic [DATA_W-1:0] data_age [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_age
            logic [PTR_W-1:0] idx;
            assign idx           = head + PTR_W'(gi);
            assign match_age[gi] = (CNT_W'(gi) < count) && (entry_adr[idx] == ld_adr);
            assign data_age[gi]  = entry_data[idx];
        end
    endgenerate

    // Scan oldest to youngest so the last (youngest) match wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (match_age[k]) begin
                hit  = 1'b1;
                data = data_age[k];
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between the EX/MEM register and DataMemory; owns the memory port.
// Committed stores queue in a circular FIFO and drain one per cycle while no
// load needs the port. Loads forward from the youngest matching store, else
// read DataMemory combinationally.
//   st_valid/st_adr/st_data/st_ready : store push interface
//   ld_valid/ld_adr/ld_data/ld_hit   : same-cycle load interface
//   mem_w/mem_r/mem_adr/mem_datain   : DataMemory control, mem_dataout returns data
//   count/empty                      : occupancy, used by fence/halt logic
module store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     st_valid,
    input  logic [ADDR_W-1:0]        st_adr,
    input  logic [DATA_W-1:0]        st_data,
    output logic                     st_ready,
    input  logic                     ld_valid,
    input  logic [ADDR_W-1:0]        ld_adr,
    output logic [DATA_W-1:0]        ld_data,
    output logic                     ld_hit,
    output logic                     mem_w,
    output logic                     mem_r,
    output logic [ADDR_W-1:0]        mem_adr,
    output logic [DATA_W-1:0]        mem_datain,
    input  logic [DATA_W-1:0]        mem_dataout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  head_reg, tail_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [ADDR_W-1:0] adr_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic              push;
    logic              drain;
    port_mode_t        port_mode;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    // Ready depends on registered occupancy only: a full buffer refuses a
    // store even in a cycle where it also drains.
    assign st_ready = (count_reg != CNT_W'(DEPTH));
    assign push     = st_valid && st_ready;
    assign count    = count_reg;
    assign empty    = (count_reg == '0);

    // Port arbitration. Gated by rst_n so the port is quiet while reset is held.
    always_comb begin
        port_mode = PORT_IDLE;
        if (rst_n) begin
            if (ld_valid) begin
                port_mode = PORT_LOAD;
            end else if (count_reg != '0) begin
                port_mode = PORT_DRAIN;
            end
        end
    end

    assign drain = (port_mode == PORT_DRAIN);

    always_comb begin
        mem_w      = 1'b0;
        mem_r      = 1'b0;
        mem_adr    = adr_mem[head_reg];
        mem_datain = data_mem[head_reg];
        ld_hit     = 1'b0;
        ld_data    = '0;
        case (port_mode)
            PORT_LOAD: begin
                mem_r   = 1'b1;
                mem_adr = ld_adr;
                ld_hit  = fwd_hit;
                ld_data = fwd_hit ? fwd_data : mem_dataout;
            end
            PORT_DRAIN: begin
                mem_w = 1'b1;
            end
            default: ;
        endcase
    end

    sb_fwd_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fwd (
        .entry_adr  (adr_mem),
        .entry_data (data_mem),
        .head       (head_reg),
        .count      (count_reg),
        .ld_adr     (ld_adr),
        .hit        (fwd_hit),
        .data       (fwd_data)
    );

    // Pointers and occupancy. Power-of-two DEPTH makes the +1 wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) begin
                tail_reg <= tail_reg + PTR_W'(1);
            end
            if (drain) begin
                head_reg <= head_reg + PTR_W'(1);
            end
            case ({push, drain})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Entry storage needs no reset: slots outside [head, head+count) are ignored.
    always_ff @(posedge clk) begin
        if (push) begin
            adr_mem[tail_reg]  <= st_adr;
            data_mem[tail_reg] <= st_data;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
    import sb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st_valid = 1'b0;
    logic [63:0] st_adr = '0;
    logic [63:0] st_data = '0;
    logic        st_ready;
    logic        ld_valid = 1'b0;
    logic [63:0] ld_adr = '0;
    logic [63:0] ld_data;
    logic        ld_hit;
    logic        mem_w;
    logic        mem_r;
    logic [63:0] mem_adr;
    logic [63:0] mem_datain;
    logic [63:0] mem_dataout;
    logic [2:0]  count;
    logic        empty;

    // DataMemory stand-in: every word reads as ten times its address.
    assign mem_dataout = mem_adr * 64'd10;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(4), .ADDR_W(64), .DATA_W(64)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .st_valid    (st_valid),
        .st_adr      (st_adr),
        .st_data     (st_data),
        .st_ready    (st_ready),
        .ld_valid    (ld_valid),
        .ld_adr      (ld_adr),
        .ld_data     (ld_data),
        .ld_hit      (ld_hit),
        .mem_w       (mem_w),
        .mem_r       (mem_r),
        .mem_adr     (mem_adr),
        .mem_datain  (mem_datain),
        .mem_dataout (mem_dataout),
        .count       (count),
        .empty       (empty)
    );

    typedef struct {
        logic [63:0] adr;
        logic        hit;
        logic [63:0] data;
    } ld_exp_t;

    sb_entry_t wr_q[$];
    ld_exp_t   ld_q[$];

    int  checks = 0;
    int  fails  = 0;
    int  model_cnt = 0;
    int  exp_cnt = 0;
    bit  exp_drain = 0;
    bit  exp_ld = 0;
    bit  mon_en = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: expectations are queued, the monitor checks them
    // at the following falling edge.
    task automatic cycle(input bit sv, input logic [63:0] sa, input logic [63:0] sd,
                         input bit lv, input logic [63:0] la,
                         input bit eh, input logic [63:0] ed);
        bit acc;
        st_valid  = sv;
        st_adr    = sa;
        st_data   = sd;
        ld_valid  = lv;
        ld_adr    = la;
        exp_cnt   = model_cnt;
        exp_drain = !lv && (model_cnt != 0);
        exp_ld    = lv;
        acc       = sv && (model_cnt != 4);
        if (acc) wr_q.push_back('{adr: sa, data: sd});
        if (lv)  ld_q.push_back('{la, eh, ed});
        $display("cycle t=%0t st=%0b(%0d,%0d) acc=%0b ld=%0b(%0d) drain=%0b cnt=%0d",
                 $time, sv, sa, sd, acc, lv, la, exp_drain, model_cnt);
        mon_en = 1;
        @(posedge clk);
        model_cnt = model_cnt + int'(acc) - int'(exp_drain);
        #1;
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            check("count", 64'(count), 64'(exp_cnt));
            check("empty", 64'(empty), 64'(exp_cnt == 0));
            check("st_ready", 64'(st_ready), 64'(exp_cnt != 4));
            check("mem_w", 64'(mem_w), 64'(exp_drain));
            check("mem_r", 64'(mem_r), 64'(exp_ld));
            if (mem_w) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_write", 64'(1), 64'(0));
                end else begin
                    sb_entry_t e;
                    e = wr_q.pop_front();
                    check("drain_adr", mem_adr, e.adr);
                    check("drain_data", mem_datain, e.data);
                end
            end
            if (ld_valid) begin
                if (ld_q.size() == 0) begin
                    check("unexpected_load", 64'(1), 64'(0));
                end else begin
                    ld_exp_t l;
                    l = ld_q.pop_front();
                    check("ld_mem_adr", mem_adr, l.adr);
                    check("ld_hit", 64'(ld_hit), 64'(l.hit));
                    check("ld_data", ld_data, l.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Outputs while reset is held
        #3;
        check("rst_count", 64'(count), 64'(0));
        check("rst_empty", 64'(empty), 64'(1));
        check("rst_st_ready", 64'(st_ready), 64'(1));
        check("rst_mem_w", 64'(mem_w), 64'(0));
        check("rst_mem_r", 64'(mem_r), 64'(0));
        check("rst_ld_hit", 64'(ld_hit), 64'(0));
        check("rst_ld_data", ld_data, 64'(0));
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset then idle
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0, 0, 0);

        // Store then drain
        cycle(1, 3, 42, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);

        // Forward youngest (loads held so nothing drains)
        cycle(1, 5, 11, 1, 100, 0, 1000);
        cycle(1, 5, 22, 1, 100, 0, 1000);
        cycle(0, 0, 0, 1, 5, 1, 22);
        // Miss path
        cycle(0, 0, 0, 1, 1, 0, 10);
        // Drain the two adr-5 stores
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);

        // Full: four stores under loads, tail wraps during the fill
        for (int i = 0; i < 4; i++) cycle(1, 64'(i), 64'(100 + i), 1, 100, 0, 1000);
        cycle(1, 9, 999, 1, 2, 1, 102);         // 5th store refused, hit on adr 2
        cycle(0, 0, 0, 1, 9, 0, 90);            // refused store not forwarded
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0, 0);
        // Refill four more and drain again
        for (int i = 0; i < 4; i++) cycle(1, 64'(10 + i), 64'(200 + i), 1, 100, 0, 1000);
        cycle(0, 0, 0, 1, 12, 1, 202);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0, 0);

        // Push during drain keeps count
        cycle(1, 20, 300, 1, 100, 0, 1000);
        cycle(1, 21, 301, 1, 100, 0, 1000);
        cycle(1, 22, 302, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 22, 1, 302);          // count still 2
        cycle(0, 0, 0, 0, 0, 0, 0);             // drains 301, count 2 -> 1

        // Asynchronous reset mid-cycle with a drain pending
        mon_en = 0;
        st_valid = 0;
        ld_valid = 0;
        #1;
        check("pre_rst_mem_w", 64'(mem_w), 64'(1));
        check("pre_rst_count", 64'(count), 64'(1));
        #1;
        rst_n = 1'b0;
        #1;
        check("async_count", 64'(count), 64'(0));
        check("async_mem_w", 64'(mem_w), 64'(0));
        check("async_empty", 64'(empty), 64'(1));
        ld_valid = 1;
        ld_adr = 22;
        #1;
        check("async_mem_r", 64'(mem_r), 64'(0));
        check("async_ld_hit", 64'(ld_hit), 64'(0));
        check("async_ld_data", ld_data, 64'(0));
        ld_valid = 0;
        wr_q.delete();
        model_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 22, 0, 220);          // discarded store no longer forwards
        mon_en = 0;
        st_valid = 0;
        ld_valid = 0;

        check("wr_q_drained", 64'(wr_q.size()), 64'(0));
        check("ld_q_drained", 64'(ld_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Sits between the EX/MEM pipeline register and DataMemory and owns the memory port.
- Accepts committed stores into a small FIFO and drains them to DataMemory one per cycle when the port is idle.
- Loads have priority on the port. A load is answered by forwarding from the youngest matching buffered store, otherwise from DataMemory.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, 2..16.
- ADDR_W, 64, address width.
- DATA_W, 64, data width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- st_valid  in  1  store request from the MEM stage.
- st_adr  in  ADDR_W  store address.
- st_data  in  DATA_W  store data.
- st_ready  out  1  buffer can accept a store this cycle.
- ld_valid  in  1  load request from the MEM stage.
- ld_adr  in  ADDR_W  load address.
- ld_data  out  DATA_W  load result, same cycle.
- ld_hit  out  1  ld_data came from the buffer.
- mem_w  out  1  DataMemory write enable.
- mem_r  out  1  DataMemory read enable.
- mem_adr  out  ADDR_W  DataMemory address.
- mem_datain  out  DATA_W  DataMemory write data.
- mem_dataout  in  DATA_W  DataMemory combinational read data.
- count  out  $clog2(DEPTH)+1  number of occupied entries.
- empty  out  1  count == 0; used by fence and halt logic.

Behaviour:
- Clock is clk. Reset rst_n is asynchronous, active-low.
- Reset clears head, tail and count and discards pending stores; entry contents are don't-care.
- Outputs during and after reset:
  - count=0, empty=1, st_ready=1.
  - mem_w=0, mem_r=0, ld_hit=0, ld_data=0.
- Storage: circular FIFO with head (oldest) and tail pointers, each $clog2(DEPTH) bits, wrapping modulo DEPTH. count is held separately so full and empty are unambiguous.
- st_ready = (count != DEPTH). The decision is registered-state only: no push when full, even if a drain happens the same cycle.
- Push: on st_valid && st_ready, write {st_adr, st_data} at tail and advance tail at the clock edge. st_valid while not ready is ignored; the upstream stall logic must hold the store.
- Port arbitration is combinational, with two states:
  - LOAD (ld_valid=1): mem_r=1, mem_w=0, mem_adr=ld_adr, no drain.
  - DRAIN (ld_valid=0 && count!=0): mem_w=1, mem_r=0, mem_adr/mem_datain = head entry. Head advances at the edge.
  - Otherwise mem_w=0, mem_r=0, and mem_adr/mem_datain hold the head entry values.
- Drain latency: a store pushed at edge N is written to DataMemory at the earliest at edge N+1, provided there are no loads and the buffer was otherwise empty.
- Forwarding:
  - ld_hit = ld_valid && any valid entry address == ld_adr (full ADDR_W compare).
  - When several entries match, the youngest one (closest to tail) wins.
  - ld_data = hit ? entry data : mem_dataout, and is 0 when ld_valid=0.
  - A store being pushed in the same cycle is not visible to that cycle's load. The hazard unit orders a store before a same-address load by at least one cycle.
- Simultaneous push and drain: count unchanged, both pointers advance.
- Pointer wrap: tail==DEPTH-1 advances to 0; the same rule applies to head.
- Continuous loads starve the drain. No timeout; the pipeline guarantees bubbles.
- If reset is asserted mid-drain, the in-flight write still completes at that edge only if rst_n is high at the edge; otherwise it is dropped.

Decomposition:
- Package sb_pkg holds:
  - typedef sb_entry_t {logic [ADDR_W-1:0] adr; logic [DATA_W-1:0] data;}.
  - Localparams for default widths and DEPTH.
- One natural sub-module: sb_fwd_match, a combinational youngest-match priority search. Inputs are the entry array, head and count; outputs are hit and data.

Test Plan:
- Reset then idle:
  - Expected: count=0, empty=1, st_ready=1, mem_w=0, mem_r=0 across 5 cycles.
- Store then drain:
  - Stimulus: push adr=3, data=64'd42; ld_valid=0.
  - Expected: next cycle mem_w=1, mem_adr=3, mem_datain=42. Following cycle empty=1.
- Forward youngest:
  - Stimulus: with loads held continuously, push (5,11) then (5,22), then load adr=5.
  - Expected: ld_hit=1, ld_data=22, count=2, mem_w=0.
- Miss path:
  - Stimulus: buffer holds (5,22); load adr=1 with mem_dataout=10.
  - Expected: ld_hit=0, ld_data=10, mem_r=1, mem_adr=1.
- Full and wrap:
  - Stimulus: with loads active, push 4 stores (adr 0..3, data 100..103).
  - Expected: st_ready=0, and a 5th st_valid is ignored.
  - Stimulus: release loads.
  - Expected: drains in order 100,101,102,103 on consecutive cycles. After refilling 4 more, tail wraps and order is preserved.
- Push+drain together and async reset:
  - Stimulus: count=2, push during a drain cycle.
  - Expected: count stays 2.
  - Stimulus: assert rst_n low mid-cycle.
  - Expected: count=0 and mem_w=0 immediately, without waiting for clk.
